// File: rtl/spi_pkg.sv
// spi_pkg
//   Shared definitions for the VoSPI master SPI blocks (transmit and receive).
//   - spi_state_e : frame sequencer states
//   - SPI_CPOL / SPI_CPHA : SPI mode 3 (clock idles high, data sampled on the
//     rising edge, which is the trailing edge of each clock pulse)
//   - sclk_level() : SCLK level for the idle/high phase or the low phase
package spi_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_SHIFT = 2'd2,
      ST_HOLD  = 2'd3
   } spi_state_e;

   localparam logic SPI_CPOL = 1'b1;
   localparam logic SPI_CPHA = 1'b1;

   // SCLK sits at the CPOL level except during the active (low) half-period.
   function automatic logic sclk_level(input logic active_phase);
      return active_phase ? ~SPI_CPOL : SPI_CPOL;
   endfunction

endpackage

// File: rtl/piso_shift_register.sv
// piso_shift_register
//   Parallel-in, serial-out shift register, MSB first.
//   Ports:
//     clk_i      system clock, rising edge
//     reset_n_i  synchronous active-low reset, clears the register
//     load_i     load data_i (has priority over shift_i)
//     data_i     parallel word
//     shift_i    shift left by one, zero fill
//     serial_o   current MSB (directly from the register)
module piso_shift_register #(
   parameter int width_p = 16
) (
   input  logic               clk_i,
   input  logic               reset_n_i,
   input  logic               load_i,
   input  logic [width_p-1:0] data_i,
   input  logic               shift_i,
   output logic               serial_o
);

   logic [width_p-1:0] shift_q;

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         shift_q <= '0;
      end else if (load_i) begin
         shift_q <= data_i;
      end else if (shift_i) begin
         shift_q <= {shift_q[width_p-2:0], 1'b0};
      end
   end

   assign serial_o = shift_q[width_p-1];

endmodule

// File: rtl/spi_word_tx.sv
// spi_word_tx
//   SPI mode 3 word transmitter: one width_p-bit word per CS_N frame, MSB first.
//   Handshake: a word is accepted on a rising clk_i edge where valid_i and
//   ready_o are both high; ready_o is high only while idle, valid_i at any
//   other time is ignored and nothing is queued.
//   Ports:
//     clk_i, reset_n_i  clock, synchronous active-low reset
//     data_i, valid_i   word to send and its valid strobe
//     ready_o           idle, can accept a word
//     sclk_o            SPI clock, idles high
//     mosi_o            serial data, 0 outside the SETUP..HOLD window
//     cs_n_o            chip select, active low
//     busy_o            frame in progress
//     done_o            one-cycle pulse in the first idle cycle after a frame
//   Frame: SETUP (clk_div_p) -> SHIFT (2*clk_div_p per bit) -> HOLD (clk_div_p).
//   All outputs come straight from flops, computed from the next state.
module spi_word_tx
   import spi_pkg::*;
#(
   parameter int width_p   = 16,
   parameter int clk_div_p = 4
) (
   input  logic               clk_i,
   input  logic               reset_n_i,
   input  logic [width_p-1:0] data_i,
   input  logic               valid_i,
   output logic               ready_o,
   output logic               sclk_o,
   output logic               mosi_o,
   output logic               cs_n_o,
   output logic               busy_o,
   output logic               done_o
);

   localparam int PHASE_W = (clk_div_p > 1) ? $clog2(clk_div_p) : 1;
   localparam int BIT_W   = $clog2(width_p + 1);
   localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(clk_div_p - 1);
   localparam logic [BIT_W-1:0]   BIT_LAST   = BIT_W'(width_p - 1);

   spi_state_e         state_q, state_d;
   logic [PHASE_W-1:0] phase_q, phase_d;
   logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic               high_q, high_d;     // 0: SCLK low half, 1: high half
   logic               done_d;
   logic               sclk_q, cs_n_q, ready_q, busy_q, done_q;

   logic               accept;
   logic               phase_last;
   logic               sr_load, sr_shift;
   logic [width_p:0]   sr_load_word;

   assign accept     = valid_i && ready_q;
   assign phase_last = (phase_q == PHASE_LAST);

   // The shift register carries one extra zero guard bit above the word, so
   // MOSI is 0 during SETUP; the first shift (end of SETUP) exposes the MSB,
   // and each later shift happens at the end of a bit's high phase. The last
   // bit is not shifted out so MOSI holds data[0] through HOLD, and leaving
   // HOLD reloads zero so MOSI idles low.
   always_comb begin
      state_d      = state_q;
      phase_d      = phase_q;
      bit_cnt_d    = bit_cnt_q;
      high_d       = high_q;
      done_d       = 1'b0;
      sr_load      = 1'b0;
      sr_shift     = 1'b0;
      sr_load_word = {1'b0, data_i};

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d   = ST_SETUP;
               phase_d   = '0;
               bit_cnt_d = '0;
               high_d    = 1'b0;
               sr_load   = 1'b1;
            end
         end
         ST_SETUP: begin
            if (phase_last) begin
               state_d  = ST_SHIFT;
               phase_d  = '0;
               high_d   = 1'b0;
               sr_shift = 1'b1;
            end else begin
               phase_d = phase_q + 1'b1;
            end
         end
         ST_SHIFT: begin
            if (phase_last) begin
               phase_d = '0;
               if (!high_q) begin
                  high_d = 1'b1;
               end else begin
                  high_d    = 1'b0;
                  bit_cnt_d = bit_cnt_q + 1'b1;
                  if (bit_cnt_q == BIT_LAST) begin
                     state_d = ST_HOLD;
                  end else begin
                     sr_shift = 1'b1;
                  end
               end
            end else begin
               phase_d = phase_q + 1'b1;
            end
         end
         ST_HOLD: begin
            if (phase_last) begin
               state_d      = ST_IDLE;
               phase_d      = '0;
               done_d       = 1'b1;
               sr_load      = 1'b1;
               sr_load_word = '0;
            end else begin
               phase_d = phase_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state_q   <= ST_IDLE;
         phase_q   <= '0;
         bit_cnt_q <= '0;
         high_q    <= 1'b0;
         sclk_q    <= SPI_CPOL;
         cs_n_q    <= 1'b1;
         ready_q   <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         phase_q   <= phase_d;
         bit_cnt_q <= bit_cnt_d;
         high_q    <= high_d;
         sclk_q    <= sclk_level((state_d == ST_SHIFT) && !high_d);
         cs_n_q    <= (state_d == ST_IDLE);
         ready_q   <= (state_d == ST_IDLE);
         busy_q    <= (state_d != ST_IDLE);
         done_q    <= done_d;
      end
   end

   piso_shift_register #(
      .width_p (width_p + 1)
   ) u_piso (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .load_i    (sr_load),
      .data_i    (sr_load_word),
      .shift_i   (sr_shift),
      .serial_o  (mosi_o)
   );

   assign sclk_o  = sclk_q;
   assign cs_n_o  = cs_n_q;
   assign ready_o = ready_q;
   assign busy_o  = busy_q;
   assign done_o  = done_q;

endmodule

// File: doc/spi_word_tx.md
Name: spi_word_tx

Overview:
- Parallel-in, serial-out SPI transmitter for the VoSPI master; the transmit counterpart of the team's serial-in/parallel-out shift register.
- Accepts one width_p-bit word per valid/ready handshake and drives it MSB first on MOSI.
- Generates SCLK (SPI mode 3: CPOL=1, CPHA=1) and CS_N framing.
- Used for command/config writes toward the sensor; one transaction is exactly one word.

Parameters:
- width_p, 16, bits per word / per CS_N frame; minimum 2.
- clk_div_p, 4, clk_i cycles per SCLK half-period; also the CS setup and hold length; minimum 1.

Ports:
- clk_i  in  1  system clock; all logic on the rising edge.
- reset_n_i  in  1  synchronous, active-low reset.
- data_i  in  width_p  word to transmit; sampled only on accept.
- valid_i  in  1  data_i is valid.
- ready_o  out  1  block can accept a word; high only in IDLE.
- sclk_o  out  1  SPI clock; idles high.
- mosi_o  out  1  serial data, MSB first.
- cs_n_o  out  1  chip select, active low.
- busy_o  out  1  high whenever state != IDLE.
- done_o  out  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset (reset_n_i=0 at an edge):
  - Next cycle: state=IDLE, sclk_o=1, cs_n_o=1, mosi_o=0, ready_o=1, busy_o=0, done_o=0.
  - Shift register and counters cleared.
  - Reset mid-frame aborts the frame immediately with no done_o pulse.
- Accept: valid_i&&ready_o at edge E0.
  - data_i is latched into the shift register.
  - Later changes to data_i are ignored.
  - valid_i while busy is ignored; no queueing.
- States: IDLE -> SETUP -> SHIFT -> HOLD -> IDLE. All outputs are registered.
- SETUP (clk_div_p cycles after E0): cs_n_o=0, sclk_o=1, mosi_o=0.
- SHIFT (width_p bits, 2*clk_div_p cycles per bit):
  - Low phase (clk_div_p cycles): sclk_o=0; mosi_o = current bit, updated on the first low-phase cycle (falling SCLK edge).
  - High phase (clk_div_p cycles): sclk_o=1; mosi_o stable. The slave samples on the rising SCLK edge.
  - Bit order: data[width_p-1] down to data[0].
  - Shift-register advance and bit-counter increment both occur at the end of each high phase.
- HOLD (clk_div_p cycles): cs_n_o=0, sclk_o=1, mosi_o holds data[0].
- Return to IDLE:
  - First IDLE cycle: cs_n_o=1, mosi_o=0, done_o=1 for exactly one cycle, ready_o=1.
  - A new accept is allowed in that same cycle (back-to-back frames). CS_N is then high for exactly 1 cycle between frames.
- Frame timing:
  - cs_n_o is low for exactly clk_div_p*(2*width_p+2) cycles.
  - done_o is asserted clk_div_p*(2*width_p+2)+1 cycles after E0.
- Counters:
  - Phase counter width $clog2(clk_div_p) (min 1); wraps at clk_div_p-1.
  - Bit counter width $clog2(width_p+1); SHIFT exits when it reaches width_p.
- clk_div_p=1: sclk_o toggles every clk_i cycle; setup and hold are 1 cycle each.
- sclk_o never glitches: it is high in all states except the SHIFT low phase.

Decomposition:
- Shared package (spi_pkg): state enum (ST_IDLE, ST_SETUP, ST_SHIFT, ST_HOLD) and SPI mode constants (CPOL=1, CPHA=1). Reused by the receive side.
- One sub-module: piso_shift_register.
  - Ports: clk_i, reset_n_i, load_i, data_i, shift_i, serial_o.
  - Parallel load; shift left on shift_i; serial_o = MSB.
  - spi_word_tx instantiates it; the FSM, counters and SCLK/CS_N generation stay in the top.

Test Plan:
1. width_p=16, clk_div_p=2, accept 0xA5C3 -> MOSI sampled on the 16 SCLK rising edges = 1010 0101 1100 0011; cs_n_o low exactly 68 cycles; done_o single pulse 69 cycles after accept; sclk_o has exactly 16 rising edges while cs_n_o=0.
2. valid_i held high with 0x1234 then 0xFFFF -> two frames; cs_n_o high exactly 1 cycle between them; the second accept happens in the done_o cycle; both words are correct on MOSI.
3. Accept 0x8001, then change data_i to 0x0000 and pulse valid_i during SHIFT -> MOSI still carries 0x8001; no second frame; ready_o=0 throughout busy.
4. reset_n_i=0 for one cycle after bit 5 of 0xFFFF -> next cycle cs_n_o=1, sclk_o=1, mosi_o=0, ready_o=1; no done_o pulse; a new accept of 0x00FF then transmits correctly.
5. clk_div_p=1, width_p=8, accept 0x5A -> sclk_o toggles every cycle; cs_n_o low 18 cycles; MOSI = 0101 1010.
6. Idle for 20 cycles after reset with valid_i=0 -> sclk_o=1, cs_n_o=1, mosi_o=0, done_o=0 constant.
